// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encodings, access sizes and IO-range helpers shared by mem_ctrl
package mem_ctrl_pkg;
    localparam int MC_IF_LINE_BYTES = 64;
    localparam logic [1:0] LSB_SIZE_B = 2'd0;
    localparam logic [1:0] LSB_SIZE_H = 2'd1;
    localparam logic [1:0] LSB_SIZE_W = 2'd2;
    localparam logic [1:0] MC_IO_RANGE = 2'b11;
    typedef enum logic [1:0] {MC_IDLE, MC_IF_READ, MC_LS_READ, MC_LS_WRITE} state_t;
    function automatic logic [1:0] size_last(input logic [1:0] size);
        return (size == LSB_SIZE_W) ? 2'd3 : (size == LSB_SIZE_H) ? 2'd1 : (size == LSB_SIZE_B) ? 2'd0 : 2'd3;
    endfunction
    function automatic logic is_io(input logic [1:0] hi);
        return hi == MC_IO_RANGE;
    endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial fetch/load-store memory controller; MC_IO_STALL_EN holds IO-range stores while io_buffer_full
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int IF_LINE_BYTES = MC_IF_LINE_BYTES,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic [7:0]                 mem_din,
    output logic [7:0]                 mem_dout,
    output logic [ADDR_W-1:0]          mem_a,
    output logic                       mem_wr,
    input  logic                       io_buffer_full,
    input  logic                       if_en,
    input  logic [ADDR_W-1:0]          if_pc,
    output logic                       if_done,
    output logic [IF_LINE_BYTES*8-1:0] if_data,
    input  logic                       lsb_en,
    input  logic                       lsb_wr,
    input  logic [ADDR_W-1:0]          lsb_addr,
    input  logic [1:0]                 lsb_size,
    input  logic [31:0]                lsb_wdata,
    output logic                       lsb_done,
    output logic [31:0]                lsb_rdata,
    input  logic                       rollback
);
    localparam int LW = IF_LINE_BYTES * 8;
    localparam int CW = $clog2(IF_LINE_BYTES);
`ifdef MC_IO_STALL_EN
    localparam bit IO_STALL = 1'b1;
`else
    localparam bit IO_STALL = 1'b0;
`endif
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, last, last_nx;
    logic [ADDR_W-1:0] base, base_nx, mem_a_nx, addr_k;
    logic [31:0] wdata, wdata_nx, lsb_rdata_nx;
    logic [LW-1:0] line, line_nx, line_cap, if_data_nx;
    logic [7:0] mem_dout_nx;
    logic mem_wr_nx, if_done_nx, lsb_done_nx, io_full, lsb_go;
    assign io_full = IO_STALL && io_buffer_full;
    assign lsb_go = lsb_en && (lsb_wr || !rollback);
    assign addr_k = base + ADDR_W'(cnt) + ADDR_W'(1);
    function automatic logic io_busy(input logic [ADDR_W-1:0] a, input logic full);
        return full && is_io(a[17:16]);
    endfunction
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        last_nx = last;
        base_nx = base;
        wdata_nx = wdata;
        line_nx = line;
        mem_a_nx = mem_a;
        mem_wr_nx = mem_wr;
        mem_dout_nx = mem_dout;
        if_data_nx = if_data;
        lsb_rdata_nx = lsb_rdata;
        if_done_nx = 1'b0;
        lsb_done_nx = 1'b0;
        line_cap = line;
        line_cap[{cnt, 3'b000} +: 8] = mem_din;
        unique case (state)
            MC_IDLE: if (!if_done && !lsb_done) begin
                if (lsb_go) begin
                    base_nx = lsb_addr;
                    wdata_nx = lsb_wdata;
                    last_nx = CW'(size_last(lsb_size));
                    cnt_nx = '0;
                    mem_a_nx = lsb_addr;
                    line_nx = '0;
                    state_nx = lsb_wr ? MC_LS_WRITE : MC_LS_READ;
                    mem_dout_nx = lsb_wr ? lsb_wdata[7:0] : mem_dout;
                    mem_wr_nx = lsb_wr && !io_busy(lsb_addr, io_full);
                end else if (if_en) begin
                    base_nx = if_pc;
                    last_nx = CW'(IF_LINE_BYTES - 1);
                    cnt_nx = '0;
                    mem_a_nx = if_pc;
                    state_nx = MC_IF_READ;
                end
            end
            MC_IF_READ, MC_LS_READ: if (state == MC_LS_READ && rollback) begin
                state_nx = MC_IDLE;
                mem_a_nx = '0;
            end else begin
                line_nx = line_cap;
                if (cnt == last) begin
                    state_nx = MC_IDLE;
                    mem_a_nx = '0;
                    if_done_nx = state == MC_IF_READ;
                    lsb_done_nx = state == MC_LS_READ;
                    if_data_nx = (state == MC_IF_READ) ? line_cap : if_data;
                    lsb_rdata_nx = (state == MC_LS_READ) ? line_cap[31:0] : lsb_rdata;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    mem_a_nx = addr_k;
                end
            end
            MC_LS_WRITE: if (!mem_wr) begin
                mem_wr_nx = !io_busy(mem_a, io_full);
            end else if (cnt == last) begin
                mem_wr_nx = 1'b0;
                lsb_done_nx = 1'b1;
                state_nx = MC_IDLE;
                mem_a_nx = '0;
            end else begin
                cnt_nx = cnt + 1'b1;
                mem_a_nx = addr_k;
                mem_dout_nx = wdata[15:8];
                wdata_nx = wdata >> 8;
                mem_wr_nx = !io_busy(addr_k, io_full);
            end
            default: state_nx = MC_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MC_IDLE;
            cnt <= '0;
            last <= '0;
            base <= '0;
            wdata <= '0;
            line <= '0;
            mem_a <= '0;
            mem_wr <= 1'b0;
            mem_dout <= '0;
            if_done <= 1'b0;
            lsb_done <= 1'b0;
            if_data <= '0;
            lsb_rdata <= '0;
        end else if (rdy) begin
            state <= state_nx;
            cnt <= cnt_nx;
            last <= last_nx;
            base <= base_nx;
            wdata <= wdata_nx;
            line <= line_nx;
            mem_a <= mem_a_nx;
            mem_wr <= mem_wr_nx;
            mem_dout <= mem_dout_nx;
            if_done <= if_done_nx;
            lsb_done <= lsb_done_nx;
            if_data <= if_data_nx;
            lsb_rdata <= lsb_rdata_nx;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of fills, loads, stores, arbitration, rollback and stalls
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst, rdy, mem_wr, io_buffer_full, if_en, if_done, lsb_en, lsb_wr, lsb_done, rollback;
    logic [7:0] mem_din, mem_dout;
    logic [31:0] mem_a, if_pc, lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0] lsb_size;
    logic [511:0] if_data;
    logic [31:0] ld_word = 32'h12345678;
    int tests = 0;
    int fails = 0;
    int n;
    always #5 clk = ~clk;
    // Combinational RAM image: 0x100..0x103 hold 0x12345678, every other byte equals its address LSB
    assign mem_din = (mem_a[31:2] == 30'h40) ? ld_word[{mem_a[1:0], 3'b000} +: 8] : mem_a[7:0];
    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .if_en(if_en), .if_pc(if_pc),
        .if_done(if_done), .if_data(if_data), .lsb_en(lsb_en), .lsb_wr(lsb_wr),
        .lsb_addr(lsb_addr), .lsb_size(lsb_size), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
        .lsb_rdata(lsb_rdata), .rollback(rollback)
    );
    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(input string tag, input bit lsb, output int edges);
        edges = 0;
        while (edges < 200) begin
            tick();
            edges++;
            if (lsb ? lsb_done : if_done) break;
        end
        check({tag, " done"}, lsb ? lsb_done : if_done, 1'b1);
    endtask
    task automatic release_req(input string tag);
        tick();
        lsb_en = 1'b0;
        if_en = 1'b0;
        check({tag, " one pulse"}, {if_done, lsb_done}, 2'b00);
    endtask
    task automatic lsb_req(input bit wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
        lsb_en = 1'b1;
        lsb_wr = wr;
        lsb_size = size;
        lsb_addr = addr;
        lsb_wdata = wd;
    endtask
    function automatic logic [511:0] line_exp(input logic [7:0] b);
        logic [511:0] l;
        for (int i = 0; i < 64; i++) l[8*i +: 8] = b + 8'(i);
        return l;
    endfunction
    initial begin
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; if_en = 1'b0; if_pc = '0;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0; rollback = 1'b0;
        tick();
        tick();
        check("reset outputs", {mem_a, mem_wr, mem_dout, if_done, lsb_done, lsb_rdata}, '0);
        check("reset if_data", if_data, '0);
        rst = 1'b0;
        if_en = 1'b1; if_pc = 32'h40;
        tick();
        check("fill accept addr", {mem_a, mem_wr}, {32'h40, 1'b0});
        wait_done("fill", 1'b0, n);
        check("fill latency", n, 64);
        check("fill data", if_data, line_exp(8'h40));
        release_req("fill");
        check("fill no refill", mem_a, 32'h0);
        tick();
        check("fill idle", {mem_a, if_done}, 33'h0);
        lsb_req(1'b0, 2'd2, 32'h100, 32'h0);
        tick();
        check("load accept addr", mem_a, 32'h100);
        wait_done("word load", 1'b1, n);
        check("word load latency", n, 4);
        check("word load data", lsb_rdata, 32'h12345678);
        release_req("word load");
        lsb_req(1'b0, 2'd0, 32'h103, 32'h0);
        tick();
        wait_done("byte load", 1'b1, n);
        check("byte load latency", n, 1);
        check("byte load data", lsb_rdata, 32'h00000012);
        release_req("byte load");
        lsb_req(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
        tick();
        tick();
        check("wrap addr", mem_a, 32'h0);
        tick();
        check("wrap half data", {lsb_done, lsb_rdata}, {1'b1, 32'h000000FF});
        release_req("wrap load");
        lsb_req(1'b1, 2'd1, 32'h200, 32'hAABBCCDD);
        tick();
        check("store byte0", {mem_wr, mem_a, mem_dout, lsb_done}, {1'b1, 32'h200, 8'hDD, 1'b0});
        tick();
        check("store byte1", {mem_wr, mem_a, mem_dout, lsb_done}, {1'b1, 32'h201, 8'hCC, 1'b0});
        tick();
        check("store done", {mem_wr, lsb_done, mem_a}, {1'b0, 1'b1, 32'h0});
        release_req("store");
        if_en = 1'b1; if_pc = 32'h80;
        lsb_req(1'b0, 2'd2, 32'h100, 32'h0);
        tick();
        check("contention load first", mem_a, 32'h100);
        wait_done("contention load", 1'b1, n);
        check("contention load latency", n, 4);
        tick();
        lsb_en = 1'b0;
        check("fetch held in done cycle", {mem_a, lsb_done}, 33'h0);
        tick();
        check("fetch accepted", mem_a, 32'h80);
        wait_done("contention fill", 1'b0, n);
        check("contention fill latency", n, 64);
        check("contention fill data", if_data, line_exp(8'h80));
        release_req("contention fill");
        lsb_req(1'b0, 2'd2, 32'h300, 32'h0);
        tick();
        tick();
        rollback = 1'b1;
        lsb_en = 1'b0;
        tick();
        rollback = 1'b0;
        check("rollback idle", {mem_a, mem_wr, lsb_done}, 34'h0);
        n = 0;
        repeat (5) begin
            tick();
            n += int'(lsb_done);
        end
        check("rollback no done", n, 0);
        check("rollback rdata held", lsb_rdata, 32'h12345678);
        lsb_req(1'b1, 2'd2, 32'h210, 32'h11223344);
        tick();
        tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("store past rollback", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h212, 8'h22});
        tick();
        check("store last byte", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h213, 8'h11});
        tick();
        check("store rollback done", {mem_wr, lsb_done}, 2'b01);
        release_req("rollback store");
        if_en = 1'b1; if_pc = 32'hC0;
        tick();
        repeat (10) tick();
        rdy = 1'b0;
        tick();
        check("stall addr hold", mem_a, 32'hCA);
        tick();
        tick();
        rdy = 1'b1;
        wait_done("stalled fill", 1'b0, n);
        check("stalled fill latency", n + 13, 67);
        check("stalled fill data", if_data, line_exp(8'hC0));
        release_req("stalled fill");
        io_buffer_full = 1'b1;
        lsb_req(1'b1, 2'd0, 32'h30000, 32'h5A);
        tick();
`ifdef MC_IO_STALL_EN
        check("io held", mem_wr, 1'b0);
        repeat (4) tick();
        check("io still held", {mem_wr, lsb_done}, 2'b00);
        io_buffer_full = 1'b0;
        tick();
        check("io issue", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'h5A});
        tick();
        check("io done", {mem_wr, lsb_done}, 2'b01);
`else
        check("io ignored", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'h5A});
        tick();
        check("io done", {mem_wr, lsb_done}, 2'b01);
        io_buffer_full = 1'b0;
`endif
        release_req("io store");
        if_en = 1'b1; if_pc = 32'h0;
        tick();
        repeat (5) tick();
        rst = 1'b1;
        if_en = 1'b0;
        tick();
        rst = 1'b0;
        check("mid reset", {mem_a, mem_wr, if_done, lsb_rdata}, '0);
        check("mid reset if_data", if_data, '0);
        tick();
        check("mid reset no done", {if_done, mem_a}, 33'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the instruction-fetch line-fill protocol and of the load/store-buffer memory port.
- Sits between the fetch unit, the load/store buffer and the byte-wide single-port RAM/IO bus.
- Serialises each request into byte accesses, assembles read data little-endian and pulses a one-cycle done per request.
- Arbitrates between the two requesters and never runs more than one operation at a time.

Parameters:
- IF_LINE_BYTES, 64, bytes per fetch line; if_data width is IF_LINE_BYTES*8.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs hold
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1=write, 0=read
- io_buffer_full  in  1  IO write buffer full (see optional feature)
- if_en  in  1  fetch request; held until if_done is seen
- if_pc  in  ADDR_W  line-aligned fetch address
- if_done  out  1  one-cycle line-ready pulse
- if_data  out  IF_LINE_BYTES*8  line data; byte i at bits [8i+7:8i]
- lsb_en  in  1  load/store request; held until lsb_done is seen
- lsb_wr  in  1  1=store, 0=load
- lsb_addr  in  ADDR_W  byte address
- lsb_size  in  2  0=byte, 1=half, 2=word; 3 is illegal
- lsb_wdata  in  32  store data, little-endian
- lsb_done  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, zero-extended; sign extension is done by the LSB
- rollback  in  1  pipeline flush

Behaviour:
- Reset: state=IDLE; mem_a=0; mem_wr=0; mem_dout=0; if_done=0; lsb_done=0; if_data=0; lsb_rdata=0; byte counter=0.
- States:
  - IDLE: no access in progress.
  - IF_READ: fetch line fill.
  - LS_READ: load.
  - LS_WRITE: store.
- IDLE acceptance:
  - A request is accepted only if if_done=0 and lsb_done=0 in that cycle. Requesters drop en one edge after seeing done, so en is ignored in the done cycle.
  - If both requests are pending, lsb_en wins; the fetch request waits.
  - N = IF_LINE_BYTES for fetch; N = 1/2/4 for the load/store buffer.
- Read (IF_READ or LS_READ):
  - The accept edge drives mem_a=base, mem_wr=0.
  - Edges 1..N-1 drive mem_a=base+k.
  - Edge k (1..N) captures mem_din as byte k-1 (RAM has one-cycle latency).
  - Edge N raises done with data valid, and state returns to IDLE.
  - Done is visible in the cycle after edge N. A 64-byte fill therefore completes 64 edges after acceptance.
- Write (LS_WRITE):
  - The accept edge drives byte 0: mem_a=lsb_addr, mem_dout=lsb_wdata[7:0], mem_wr=1.
  - Edge k drives byte k.
  - Edge N drops mem_wr to 0, raises lsb_done and returns to IDLE.
- Addresses are base+k with ADDR_W-bit wrap-around; no alignment check.
- In IDLE, mem_wr=0 and mem_a=0.
- Done pulses last exactly one cycle.
- if_data and lsb_rdata hold their last value until the next completion.
- rollback:
  - In LS_READ: abort to IDLE immediately, with no lsb_done and mem_wr=0.
  - In LS_WRITE: ignored; committed stores always finish.
  - In IF_READ: ignored; the fill completes and the fetch unit discards or keeps it.
  - If rollback and lsb_en are both high in IDLE, the load is not accepted; a store is accepted.
- rdy low in any state: counter, outputs and captured bytes freeze. RAM output is assumed stable across stalls.
- rst mid-operation: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: MC_IO_STALL_EN.
- Defined: in LS_WRITE, a byte whose address has [17:16]=2'b11 is not issued while io_buffer_full=1.
  - mem_wr=0 in that cycle.
  - The counter holds, and the byte is issued on the first edge with io_buffer_full=0.
- Undefined: io_buffer_full is ignored and writes issue every cycle.

Decomposition:
- macros.v gets:
  - MC_IF_LINE_BYTES.
  - The LSB_SIZE_B/H/W encodings.
  - MC_IDLE, MC_IF_READ, MC_LS_READ, MC_LS_WRITE state encodings.
  - The IO address range macro (17:16 == 2'b11).
- Single module; no sub-module is natural. The byte sequencer is one counter shared by all states.

Test Plan:
- Fetch fill: if_en=1, if_pc=0x40, RAM byte at address a = a[7:0] -> if_done 64 edges after acceptance; if_data byte i = 0x40+i; one pulse; if_en dropped in the done cycle starts no new fill.
- Word load: lsb_en=1, lsb_wr=0, lsb_size=2, lsb_addr=0x100 holding 0x78,0x56,0x34,0x12 -> lsb_rdata=0x12345678 after 4 edges; byte load at 0x103 -> 0x00000012.
- Store: lsb_wr=1, size=1, addr=0x200, wdata=0xAABBCCDD -> mem_wr=1 for two cycles, writing 0xDD@0x200 then 0xCC@0x201; lsb_done follows.
- Contention: if_en and lsb_en raised in the same cycle -> the load is served first; the fetch is accepted in the cycle after lsb_done falls.
- Rollback: rollback pulsed at edge 2 of a word load -> no lsb_done, IDLE next cycle; the same pulse during a store -> the store completes.
- rdy low for 3 cycles mid-fill, and (with MC_IO_STALL_EN) a store to 0x30000 with io_buffer_full high for 5 cycles -> done delayed by exactly 3 and 5 cycles respectively, with correct data.
